z80_bus_mem_io: RTL and testbench

//  Synthesisable Z80 bus responder for tv80s benches and FPGA bring-up: memory + IO

---
 rtl/z80_bus_mem_io_if.sv | 42 ++++
 rtl/z80_bus_mem_io.sv | 162 ++++++++++++++++
 tb/tb_z80_bus_mem_io.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/z80_bus_mem_io_if.sv
// Bus bundle between a tv80s-style CPU (or bench driver) and the memory/IO
// responder: CPU strobes and data, backdoor preload port, write-log stream.
// Handshake on the log stream: the head entry is transferred on a rising
// edge where log_valid and log_ready are both high; log_* hold steady while
// log_valid is high and log_ready is low.
interface z80_bus_mem_io_if;
   logic        m1_n;
   logic        mreq_n;
   logic        iorq_n;
   logic        rd_n;
   logic        wr_n;
   logic        rfsh_n;
   logic [15:0] A;
   logic [7:0]  dout;
   logic [7:0]  di;
   logic        wait_n;
   logic        bd_we;
   logic        bd_io;
   logic [15:0] bd_addr;
   logic [7:0]  bd_data;
   logic        log_valid;
   logic        log_ready;
   logic [15:0] log_addr;
   logic [7:0]  log_data;
   logic        log_io;
   logic        log_ovf;
   logic [1:0]  fsm_state;

   modport slave (
      input  m1_n, mreq_n, iorq_n, rd_n, wr_n, rfsh_n, A, dout,
      input  bd_we, bd_io, bd_addr, bd_data, log_ready,
      output di, wait_n, log_valid, log_addr, log_data, log_io, log_ovf,
      output fsm_state
   );

   modport master (
      output m1_n, mreq_n, iorq_n, rd_n, wr_n, rfsh_n, A, dout,
      output bd_we, bd_io, bd_addr, bd_data, log_ready,
      input  di, wait_n, log_valid, log_addr, log_data, log_io, log_ovf,
      input  fsm_state
   );
endinterface

// File: rtl/z80_bus_mem_io.sv
// Z80 bus responder: memory + IO arrays, per-space wait states, interrupt
// acknowledge vector, backdoor preload and an in-order CPU write log FIFO.
module z80_bus_mem_io #(
   parameter int         MEM_AW    = 16,
   parameter int         IO_AW     = 8,
   parameter int         MEM_WAIT  = 0,
   parameter int         IO_WAIT   = 1,
   parameter int         LOG_DEPTH = 16,
   parameter logic [7:0] IM_VECTOR = 8'hFF
) (
   input logic               clk,
   input logic               reset,
   z80_bus_mem_io_if.slave   bus
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_WAIT = 2'd1;
   localparam logic [1:0] ST_HOLD = 2'd2;

   localparam int             LOG_AW   = $clog2(LOG_DEPTH);
   localparam logic [3:0]     MEM_N    = 4'(MEM_WAIT);
   localparam logic [3:0]     IO_N     = 4'(IO_WAIT);
   localparam logic [LOG_AW:0] LOG_FULL = (LOG_AW + 1)'(LOG_DEPTH);

   logic [7:0]  mem    [2**MEM_AW];
   logic [7:0]  io_mem [2**IO_AW];
   logic [24:0] log_mem [LOG_DEPTH];

   logic [1:0]  state;
   logic [3:0]  cnt;
   logic        committed;
   logic        acc_inta;

   logic [LOG_AW:0] wptr;
   logic [LOG_AW:0] rptr;
   logic            ovf;

   logic            inta;
   logic            start;
   logic [3:0]      n_wait;
   logic            commit;
   logic            commit_io;
   logic            empty;
   logic            full;
   logic            pop;
   logic            push;
   logic [24:0]     head;

   logic [MEM_AW-1:0] mem_idx;
   logic [IO_AW-1:0]  io_idx;
   logic [MEM_AW-1:0] bd_mem_idx;
   logic [IO_AW-1:0]  bd_io_idx;

   assign mem_idx    = bus.A[MEM_AW-1:0];
   assign io_idx     = bus.A[IO_AW-1:0];
   assign bd_mem_idx = bus.bd_addr[MEM_AW-1:0];
   assign bd_io_idx  = bus.bd_addr[IO_AW-1:0];

   // Access decode; interrupt acknowledge carries no rd/wr strobe but still
   // runs through the IO wait sequence. A write commits once the wait count
   // has expired: at start when no waits, otherwise on the first HOLD edge.
   always_comb begin
      inta      = !bus.m1_n && !bus.iorq_n;
      start     = (state == ST_IDLE) && bus.rfsh_n &&
                  (((!bus.mreq_n || !bus.iorq_n) && (!bus.rd_n || !bus.wr_n)) || inta);
      n_wait    = !bus.iorq_n ? IO_N : MEM_N;
      commit_io = !bus.iorq_n;
      commit    = !reset && !bus.wr_n &&
                  ((start && (n_wait == 4'd0) && !inta) ||
                   ((state == ST_HOLD) && !committed && !acc_inta));
   end

   // Access sequencer: IDLE -> optional WAIT countdown -> HOLD until strobes drop.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= ST_IDLE;
         cnt       <= 4'd0;
         committed <= 1'b0;
         acc_inta  <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start) begin
                  acc_inta  <= inta;
                  committed <= commit;
                  if (n_wait != 4'd0) begin
                     state <= ST_WAIT;
                     cnt   <= n_wait - 4'd1;
                  end else begin
                     state <= ST_HOLD;
                  end
               end
            end
            ST_WAIT: begin
               if (cnt == 4'd0) state <= ST_HOLD;
               else             cnt   <= cnt - 4'd1;
            end
            ST_HOLD: begin
               if (commit) committed <= 1'b1;
               if (bus.mreq_n && bus.iorq_n) begin
                  state     <= ST_IDLE;
                  committed <= 1'b0;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign bus.wait_n    = (state != ST_WAIT);
   assign bus.fsm_state = state;

   // Registered read data, refreshed every edge from the live bus.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)             bus.di <= 8'h00;
      else if (inta)         bus.di <= IM_VECTOR;
      else if (!bus.iorq_n)  bus.di <= io_mem[io_idx];
      else                   bus.di <= mem[mem_idx];
   end

   // Array writes; the backdoor is applied last so it wins a same-edge clash.
   always_ff @(posedge clk) begin
      if (commit && !commit_io)         mem[mem_idx]       <= bus.dout;
      if (commit && commit_io)          io_mem[io_idx]     <= bus.dout;
      if (bus.bd_we && !bus.bd_io)      mem[bd_mem_idx]    <= bus.bd_data;
      if (bus.bd_we && bus.bd_io)       io_mem[bd_io_idx]  <= bus.bd_data;
   end

   // Log FIFO control; a pop in the same cycle frees room for a push when full.
   always_comb begin
      empty = (wptr == rptr);
      full  = ((wptr - rptr) == LOG_FULL);
      pop   = !empty && bus.log_ready;
      push  = commit && (!full || pop);
      head  = log_mem[rptr[LOG_AW-1:0]];
   end

   // Log storage, unreset: only entries between the pointers are ever visible.
   always_ff @(posedge clk) begin
      if (push) log_mem[wptr[LOG_AW-1:0]] <= {bus.A, bus.dout, commit_io};
   end

   // Log pointers and sticky overflow flag.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wptr <= '0;
         rptr <= '0;
         ovf  <= 1'b0;
      end else begin
         if (push)                  wptr <= wptr + 1'b1;
         if (pop)                   rptr <= rptr + 1'b1;
         if (commit && full && !pop) ovf <= 1'b1;
      end
   end

   assign bus.log_valid = !empty;
   assign bus.log_addr  = empty ? 16'h0000 : head[24:9];
   assign bus.log_data  = empty ? 8'h00    : head[8:1];
   assign bus.log_io    = empty ? 1'b0     : head[0];
   assign bus.log_ovf   = ovf;

endmodule

// File: tb/tb_z80_bus_mem_io.sv
// Directed bench for z80_bus_mem_io acting as the CPU on the bus pins.
module tb_z80_bus_mem_io;

   localparam int LOG_DEPTH = 4;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   z80_bus_mem_io_if bus ();

   z80_bus_mem_io #(
      .MEM_AW    (16),
      .IO_AW     (8),
      .MEM_WAIT  (2),
      .IO_WAIT   (1),
      .LOG_DEPTH (LOG_DEPTH),
      .IM_VECTOR (8'hFF)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int tests = 0;
   int fails = 0;
   logic [24:0] exp_q[$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic bus_idle();
      bus.m1_n   = 1'b1;
      bus.mreq_n = 1'b1;
      bus.iorq_n = 1'b1;
      bus.rd_n   = 1'b1;
      bus.wr_n   = 1'b1;
      bus.rfsh_n = 1'b1;
   endtask

   task automatic bd_write(input logic io, input logic [15:0] a, input logic [7:0] d);
      @(negedge clk);
      bus.bd_we = 1'b1; bus.bd_io = io; bus.bd_addr = a; bus.bd_data = d;
      @(negedge clk);
      bus.bd_we = 1'b0;
   endtask

   // One complete bus access; counts wait cycles and returns di seen at the end.
   task automatic cpu_cycle(input logic is_io, input logic is_wr, input logic is_m1,
                            input logic [15:0] a, input logic [7:0] d,
                            input logic pop_at_commit, input logic bd_at_commit,
                            input logic [7:0] bd_d,
                            output int waits, output logic [7:0] rd);
      @(negedge clk);
      bus.A = a; bus.dout = d; bus.m1_n = !is_m1;
      if (is_io) bus.iorq_n = 1'b0; else bus.mreq_n = 1'b0;
      if (!(is_m1 && is_io)) begin
         if (is_wr) bus.wr_n = 1'b0; else bus.rd_n = 1'b0;
      end
      waits = 0;
      @(negedge clk);
      while (bus.wait_n === 1'b0 && waits < 20) begin
         waits++;
         @(negedge clk);
      end
      if (pop_at_commit) bus.log_ready = 1'b1;
      if (bd_at_commit) begin
         bus.bd_we = 1'b1; bus.bd_io = is_io; bus.bd_addr = a; bus.bd_data = bd_d;
      end
      @(negedge clk);
      rd = bus.di;
      bus.log_ready = 1'b0;
      bus.bd_we = 1'b0;
      bus_idle();
      @(negedge clk);
   endtask

   task automatic refresh_cycle(input logic [15:0] a, input string tag);
      @(negedge clk);
      bus.A = a; bus.mreq_n = 1'b0; bus.rfsh_n = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check({tag, "_fsm"}, 32'(bus.fsm_state), 32'd0);
      check({tag, "_wait_n"}, 32'(bus.wait_n), 32'd1);
      bus_idle();
   endtask

   // Pops the whole log and compares each head entry to the expected queue.
   task automatic drain(input string tag);
      int n = 0;
      logic [24:0] e;
      @(negedge clk);
      bus.log_ready = 1'b1;
      while (bus.log_valid === 1'b1 && n < LOG_DEPTH + 2) begin
         if (exp_q.size() > 0) e = exp_q.pop_front();
         else                  e = 'x;
         check({tag, "_entry"}, 32'({bus.log_addr, bus.log_data, bus.log_io}), 32'(e));
         n++;
         @(negedge clk);
      end
      bus.log_ready = 1'b0;
      check({tag, "_left"}, 32'(exp_q.size()), 32'd0);
      check({tag, "_empty_out"}, 32'({bus.log_valid, bus.log_addr, bus.log_data, bus.log_io}), 32'd0);
   endtask

   initial begin
      int w;
      logic [7:0] r;
      logic [7:0] prog [4];
      logic [7:0] d8;
      prog[0] = 8'hDD; prog[1] = 8'hCB; prog[2] = 8'hC4; prog[3] = 8'hAC;

      reset = 1'b1;
      bus_idle();
      bus.A = 16'h0000; bus.dout = 8'h00;
      bus.bd_we = 1'b0; bus.bd_io = 1'b0; bus.bd_addr = 16'h0000; bus.bd_data = 8'h00;
      bus.log_ready = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_di", 32'(bus.di), 32'h00);
      check("rst_wait_n", 32'(bus.wait_n), 32'd1);
      check("rst_log_valid", 32'(bus.log_valid), 32'd0);
      check("rst_log_ovf", 32'(bus.log_ovf), 32'd0);
      check("rst_fsm", 32'(bus.fsm_state), 32'd0);
      reset = 1'b0;

      // Program fetch with refresh cycles in between; reads never log.
      for (int i = 0; i < 4; i++) bd_write(1'b0, 16'(i), prog[i]);
      bd_write(1'b0, 16'hA4A1, 8'h44);
      for (int i = 0; i < 4; i++) begin
         cpu_cycle(1'b0, 1'b0, (i < 2), 16'(i), 8'h00, 1'b0, 1'b0, 8'h00, w, r);
         check($sformatf("fetch%0d_data", i), 32'(r), 32'(prog[i]));
         check($sformatf("fetch%0d_waits", i), 32'(w), 32'd2);
         refresh_cycle(16'(i + 1), $sformatf("rfsh%0d", i));
      end
      cpu_cycle(1'b0, 1'b0, 1'b0, 16'hA4A1, 8'h00, 1'b0, 1'b0, 8'h00, w, r);
      check("ix_read", 32'(r), 32'h44);
      check("ix_no_log", 32'(bus.log_valid), 32'd0);

      // Memory write with two wait states.
      cpu_cycle(1'b0, 1'b1, 1'b0, 16'h8000, 8'h5A, 1'b0, 1'b0, 8'h00, w, r);
      exp_q.push_back({16'h8000, 8'h5A, 1'b0});
      check("mw_waits", 32'(w), 32'd2);
      cpu_cycle(1'b0, 1'b0, 1'b0, 16'h8000, 8'h00, 1'b0, 1'b0, 8'h00, w, r);
      check("mw_readback", 32'(r), 32'h5A);
      drain("mw_log");

      // IO write then read with one wait state.
      cpu_cycle(1'b1, 1'b1, 1'b0, 16'hC37F, 8'hC3, 1'b0, 1'b0, 8'h00, w, r);
      exp_q.push_back({16'hC37F, 8'hC3, 1'b1});
      check("out_waits", 32'(w), 32'd1);
      cpu_cycle(1'b1, 1'b0, 1'b0, 16'hC37F, 8'h00, 1'b0, 1'b0, 8'h00, w, r);
      check("in_data", 32'(r), 32'hC3);
      check("in_waits", 32'(w), 32'd1);
      drain("io_log");

      // Backdoor and CPU write the same byte on the same edge.
      cpu_cycle(1'b0, 1'b1, 1'b0, 16'hA000, 8'h11, 1'b0, 1'b1, 8'h22, w, r);
      exp_q.push_back({16'hA000, 8'h11, 1'b0});
      cpu_cycle(1'b0, 1'b0, 1'b0, 16'hA000, 8'h00, 1'b0, 1'b0, 8'h00, w, r);
      check("clash_bd_wins", 32'(r), 32'h22);
      drain("clash_log");

      // Fill the log, overflow it, then push and pop together while full.
      for (int i = 0; i < 5; i++) begin
         d8 = 8'($urandom_range(0, 255));
         cpu_cycle(1'b0, 1'b1, 1'b0, 16'h9100 + 16'(i), d8, 1'b0, 1'b0, 8'h00, w, r);
         if (i < LOG_DEPTH) exp_q.push_back({16'h9100 + 16'(i), d8, 1'b0});
      end
      check("full_ovf", 32'(bus.log_ovf), 32'd1);
      check("full_head", 32'({bus.log_addr, bus.log_data, bus.log_io}), 32'(exp_q[0]));
      void'(exp_q.pop_front());
      d8 = 8'($urandom_range(0, 255));
      cpu_cycle(1'b0, 1'b1, 1'b0, 16'h9200, d8, 1'b1, 1'b0, 8'h00, w, r);
      exp_q.push_back({16'h9200, d8, 1'b0});
      check("pushpop_ovf_kept", 32'(bus.log_ovf), 32'd1);
      drain("full_log");
      check("ovf_sticky", 32'(bus.log_ovf), 32'd1);

      // Reset during the wait phase of a write aborts it.
      bd_write(1'b0, 16'h9000, 8'h77);
      @(negedge clk);
      bus.A = 16'h9000; bus.dout = 8'hAA; bus.mreq_n = 1'b0; bus.wr_n = 1'b0;
      @(negedge clk);
      check("abort_in_wait", 32'({bus.fsm_state, bus.wait_n}), 32'({2'd1, 1'b0}));
      reset = 1'b1;
      #1;
      check("abort_wait_n", 32'(bus.wait_n), 32'd1);
      @(negedge clk);
      bus_idle();
      @(negedge clk);
      reset = 1'b0;
      check("abort_log_valid", 32'(bus.log_valid), 32'd0);
      check("abort_ovf_clear", 32'(bus.log_ovf), 32'd0);
      cpu_cycle(1'b0, 1'b0, 1'b0, 16'h9000, 8'h00, 1'b0, 1'b0, 8'h00, w, r);
      check("abort_mem_intact", 32'(r), 32'h77);
      cpu_cycle(1'b0, 1'b0, 1'b1, 16'h0000, 8'h00, 1'b0, 1'b0, 8'h00, w, r);
      check("restart_fetch", 32'(r), 32'hDD);

      // Interrupt acknowledge and refresh leave memory and log untouched.
      cpu_cycle(1'b1, 1'b0, 1'b1, 16'h0055, 8'h00, 1'b0, 1'b0, 8'h00, w, r);
      check("inta_vector", 32'(r), 32'hFF);
      check("inta_waits", 32'(w), 32'd1);
      refresh_cycle(16'h8000, "rfsh_after_inta");
      check("inta_no_log", 32'(bus.log_valid), 32'd0);
      cpu_cycle(1'b0, 1'b0, 1'b0, 16'h8000, 8'h00, 1'b0, 1'b0, 8'h00, w, r);
      check("mem_unchanged", 32'(r), 32'h5A);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
